// File: rtl/halfduplex_ctrl.sv
// Half-duplex serial bus controller: shifts words out/in MSB first over one
// shared tristate wire, with a bus-release guard (TURN) after every transfer.
// Optional feature macro: HALFDUPLEX_PARITY_EN (even parity bit + rx_perr).
module halfduplex_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TURN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              rx_req,
    input  logic              bus_in,
    output logic              bus_out,
    output logic              bus_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef HALFDUPLEX_PARITY_EN
    output logic              rx_perr,
`endif
    output logic              busy
);

`ifdef HALFDUPLEX_PARITY_EN
    localparam int unsigned NBITS  = DATA_W + 1;
`else
    localparam int unsigned NBITS  = DATA_W;
`endif
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned TCNT_W = (TURN_CYC < 2) ? 1 : $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_TURN
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [TCNT_W-1:0]   turn_cnt_q;
    logic [NBITS-1:0]    tx_sr_q;
    logic [NBITS-2:0]    rx_sr_q;
    logic                bus_out_q;
    logic                bus_oe_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                busy_q;
    logic                tx_ready_q;
`ifdef HALFDUPLEX_PARITY_EN
    logic                rx_perr_q;
`endif

    logic [NBITS-1:0]    tx_load_c;
    logic [NBITS-1:0]    rx_word_c;

    // Word to shift out (with trailing even-parity bit when enabled) and the
    // receive word completed by the bit currently on the wire.
    always_comb begin
`ifdef HALFDUPLEX_PARITY_EN
        tx_load_c = {tx_data, ^tx_data};
`else
        tx_load_c = tx_data;
`endif
        rx_word_c = {rx_sr_q, bus_in};
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            turn_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            bus_out_q  <= 1'b0;
            bus_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
`ifdef HALFDUPLEX_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q  <= '0;
                    turn_cnt_q <= '0;
                    if (tx_valid) begin
                        state_q    <= ST_TX;
                        tx_sr_q    <= tx_load_c << 1;
                        bus_out_q  <= tx_load_c[NBITS-1];
                        bus_oe_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
                    end else if (rx_req) begin
                        state_q    <= ST_RX;
                        rx_sr_q    <= '0;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
                    end
                end
                ST_TX: begin
                    if (bit_cnt_q == CNT_W'(NBITS - 1)) begin
                        state_q    <= ST_TURN;
                        bus_oe_q   <= 1'b0;
                        bus_out_q  <= 1'b0;
                        bit_cnt_q  <= '0;
                        turn_cnt_q <= '0;
                    end else begin
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        bus_out_q  <= tx_sr_q[NBITS-1];
                        tx_sr_q    <= tx_sr_q << 1;
                    end
                end
                ST_RX: begin
                    rx_sr_q <= rx_word_c[NBITS-2:0];
                    if (bit_cnt_q == CNT_W'(NBITS - 1)) begin
                        state_q    <= ST_TURN;
                        rx_data_q  <= rx_word_c[NBITS-1 -: DATA_W];
                        rx_valid_q <= 1'b1;
`ifdef HALFDUPLEX_PARITY_EN
                        rx_perr_q  <= ^rx_word_c;
`endif
                        bit_cnt_q  <= '0;
                        turn_cnt_q <= '0;
                    end else begin
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_TURN: begin
                    if (turn_cnt_q == TCNT_W'(TURN_CYC - 1)) begin
                        state_q    <= ST_IDLE;
                        turn_cnt_q <= '0;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + TCNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    bus_oe_q   <= 1'b0;
                    bus_out_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    tx_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
`ifdef HALFDUPLEX_PARITY_EN
    assign rx_perr  = rx_perr_q;
`endif

endmodule

// File: tb/tb_halfduplex_ctrl.sv
// Directed self-checking bench for halfduplex_ctrl (DATA_W=8, TURN_CYC=2).
module tb_halfduplex_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned TC = 2;
`ifdef HALFDUPLEX_PARITY_EN
    localparam int unsigned NB = DW + 1;
`else
    localparam int unsigned NB = DW;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          rx_req;
    logic          bus_in;
    logic          bus_out;
    logic          bus_oe;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
`ifdef HALFDUPLEX_PARITY_EN
    logic          rx_perr;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic          exp_bits_q[$];
    logic [DW-1:0] exp_rx_q[$];

    halfduplex_ctrl #(.DATA_W(DW), .TURN_CYC(TC)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_req   (rx_req),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
`ifdef HALFDUPLEX_PARITY_EN
        .rx_perr  (rx_perr),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmit one word from IDLE and follow it through TURN back to IDLE.
    task automatic tx_word(input logic [DW-1:0] d);
        int oe_cnt;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = DW - 1; i >= 0; i--) exp_bits_q.push_back(d[i]);
`ifdef HALFDUPLEX_PARITY_EN
        exp_bits_q.push_back(^d);
`endif
        tick();
        tx_valid = 1'b0;
        check("tx_oe_first", 32'(bus_oe), 32'd1);
        oe_cnt = 0;
        for (int c = 0; c < int'(NB) + 4; c++) begin
            if (!bus_oe) break;
            oe_cnt++;
            if (exp_bits_q.size() > 0) check("tx_bit", 32'(bus_out), 32'(exp_bits_q.pop_front()));
            check("tx_rx_valid_quiet", 32'(rx_valid), 32'd0);
            tick();
        end
        check("tx_oe_len", 32'(oe_cnt), 32'(NB));
        check("tx_turn_bus_out", 32'(bus_out), 32'd0);
        check("tx_turn_busy", 32'(busy), 32'd1);
        for (int t = 1; t < int'(TC); t++) begin
            tick();
            check("tx_turn_oe", 32'(bus_oe), 32'd0);
            check("tx_turn_busy2", 32'(busy), 32'd1);
        end
        tick();
        check("tx_idle_busy", 32'(busy), 32'd0);
        check("tx_idle_ready", 32'(tx_ready), 32'd1);
        exp_bits_q.delete();
    endtask

    // Receive one word (plus parity bit p when enabled) from IDLE through TURN.
    task automatic rx_word(input logic [DW-1:0] d, input logic p);
        logic [NB-1:0] bits;
`ifdef HALFDUPLEX_PARITY_EN
        bits = {d, p};
`else
        bits = d;
        if (p) bits = d;
`endif
        tx_valid = 1'b0;
        rx_req   = 1'b1;
        tick();
        rx_req = 1'b0;
        check("rx_busy", 32'(busy), 32'd1);
        check("rx_ready_low", 32'(tx_ready), 32'd0);
        exp_rx_q.push_back(d);
        for (int i = int'(NB) - 1; i >= 0; i--) begin
            bus_in = bits[i];
            check("rx_oe", 32'(bus_oe), 32'd0);
            check("rx_valid_early", 32'(rx_valid), 32'd0);
            tick();
        end
        bus_in = 1'b0;
        check("rx_valid_pulse", 32'(rx_valid), 32'd1);
        check("rx_turn_oe", 32'(bus_oe), 32'd0);
        check("rx_data", 32'(rx_data), 32'(exp_rx_q[0]));
`ifdef HALFDUPLEX_PARITY_EN
        check("rx_perr", 32'(rx_perr), 32'(^bits));
`endif
        for (int t = 1; t < int'(TC); t++) begin
            tick();
            check("rx_valid_single", 32'(rx_valid), 32'd0);
            check("rx_data_hold", 32'(rx_data), 32'(exp_rx_q[0]));
        end
        void'(exp_rx_q.pop_front());
        tick();
        check("rx_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int bursts, gap, total, rv;
        logic prev_oe;

        rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_req = 1'b0; bus_in = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'(bus_oe), 32'd0);
        check("rst_bus_out", 32'(bus_out), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        tick();

        tx_word(8'hA5);
        rx_word(8'h69, 1'b0);

        // Both requests high: TX wins, rx_req held and only taken after IDLE.
        rx_req = 1'b1;
        tx_word(8'h3C);
        rx_word(8'hC3, 1'b0);

        // Back-to-back transmit with tx_valid held.
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        for (int i = 0; i < int'(DW); i++) exp_bits_q.push_back(1'b1);
`ifdef HALFDUPLEX_PARITY_EN
        exp_bits_q.push_back(1'b0);
`endif
        for (int i = 0; i < int'(DW); i++) exp_bits_q.push_back(1'b0);
`ifdef HALFDUPLEX_PARITY_EN
        exp_bits_q.push_back(1'b0);
`endif
        tick();
        tx_data = 8'h00;
        bursts = 0; gap = 0; total = 0; prev_oe = 1'b0;
        for (int c = 0; c < 4 * int'(NB) + 10; c++) begin
            if (bus_oe) begin
                if (!prev_oe) bursts++;
                if (bursts == 2) tx_valid = 1'b0;
                total++;
                if (exp_bits_q.size() > 0) check("b2b_bit", 32'(bus_out), 32'(exp_bits_q.pop_front()));
            end else if (bursts == 1) begin
                gap++;
                check("b2b_gap_out", 32'(bus_out), 32'd0);
            end else if (bursts >= 2) begin
                break;
            end
            prev_oe = bus_oe;
            tick();
        end
        tx_valid = 1'b0;
        check("b2b_bursts", 32'(bursts), 32'd2);
        check("b2b_gap", 32'(gap), 32'(TC + 1));
        check("b2b_total", 32'(total), 32'(2 * NB));
        exp_bits_q.delete();
        for (int t = 0; t < int'(TC); t++) tick();
        check("b2b_idle", 32'(busy), 32'd0);

        tx_word(8'h07);
        rx_word(8'h07, 1'b0);

        // Reset for 2 cycles in the middle of a transmit.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        check("rstx_oe_before", 32'(bus_oe), 32'd1);
        rst = 1'b1;
        tick();
        check("rstx_oe", 32'(bus_oe), 32'd0);
        check("rstx_ready", 32'(tx_ready), 32'd1);
        check("rstx_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        rv = 0;
        for (int c = 0; c < 15; c++) begin
            if (rx_valid || bus_oe || busy) rv++;
            tick();
        end
        check("rstx_quiet", 32'(rv), 32'd0);

        // Reset in the middle of a receive: no pulse, rx_data cleared.
        rx_req = 1'b1;
        tick();
        rx_req = 1'b0;
        bus_in = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_in = 1'b0;
        check("rstr_rx_data", 32'(rx_data), 32'd0);
        rv = 0;
        for (int c = 0; c < 15; c++) begin
            if (rx_valid || busy) rv++;
            tick();
        end
        check("rstr_quiet", 32'(rv), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
